fifo_mem: RTL and testbench
===========================

# fifo_mem

Staging block for the 5x5 systolic array. Five 32-bit lane FIFOs buffer incoming row data. On an `init` pulse, a controller drains one word per lane per cycle for five cycles into a 25-word result memory laid out as a 5x5 matrix. A one-cycle `com` pulse signals completion.

## Interface
Parameters:
- `DATA_W`, default 32: word width.
- `DEPTH`, default 8: entries per lane FIFO (power of two).
- `N`, default 5: lane count and matrix dimension. Fixed at 5 by the port list.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `init`, input, 1: start request, sampled on the rising edge.
- `com`, output, 1: registered completion pulse.
- `wr_en`, input, 5: bit k pushes `in<k>` into lane FIFO k.
- `base_address`, input, 8: result-memory offset, latched at start.
- `in0`..`in4`, input, 32 each: lane data.

Port order: `init, com, clk, rst, wr_en, base_address, in0, in1, in2, in3, in4`.

## Operation
- Lane FIFO k:
  - Push on `wr_en[k]` when not full.
  - A push while full is dropped, unless the same lane pops in that cycle; then both happen.
  - Pop only under controller command.
  - A pop while empty returns nothing and causes no write.
- Result memory `mem`: 25 x DATA_W registers, index 0..24, readable hierarchically by verification.
- Controller, 1-bit state `state`: IDLE=0, RUN=1. A 3-bit row counter `row` tracks progress.
  - IDLE with `init`=1 → RUN. Latch `base_address` into `base_q`. Clear `row` to 0.
  - In RUN, each cycle, for every lane k with a non-empty FIFO: pop the FIFO and write the word to `mem[base_q + 5*row + k]`.
    - Address arithmetic is 8-bit.
    - A write whose address is ≥25 is discarded, but the pop still occurs.
  - An empty lane skips its write. The memory keeps its old value.
  - `row` increments each RUN cycle. In the cycle with `row`==4, after the writes, return to IDLE and assert `com`.
- `init` while in RUN is ignored. `init` held high re-triggers on every IDLE cycle in which it is sampled.
- Pushes continue normally during RUN.

## Timing
- Reset values:
  - `com`=0, `state`=IDLE, `row`=0, `base_q`=0.
  - All FIFOs empty, pointers 0.
  - All `mem` entries 0.
- Reset dominates `wr_en` and `init`. Pushes asserted during reset are lost.
- Let E0 be the edge that samples `init`. Row r is written at edge E(r+1), r=0..4.
- `com` rises at E5 and falls at E6: exactly one cycle high, 5 cycles after E0.
- Back-to-back: `init` high at E6 starts a new run, because IDLE is reached at E5.
- Reset asserted mid-RUN: immediate abort. No `com`. Memory is cleared.
- FIFO read data is registered-free (fall-through head), so a popped word is written at the same edge it is popped.

## Structure
- Shared package `fifo_mem_pkg`: `DATA_W`, `N`=5, `MEM_WORDS`=25, state encoding constants `S_IDLE` and `S_RUN`.
- One sub-module, `lane_fifo`: a parameterised synchronous FIFO with `push`, `pop`, `din`, `dout`, `full` and `empty`, plus the async active-high reset. It is instantiated five times.
- The controller and the result memory live in the top level.

## Test plan
- Reset and fill:
  - Hold `rst`=1 for 2 cycles with `wr_en`=5'b11111 → FIFOs stay empty and `mem` is all 0.
  - Release reset with `in0..4` held constant → after 8 cycles every FIFO is full and further pushes are dropped.
- Basic run:
  - `base_address`=0, FIFOs full, pulse `init` for 1 cycle → `mem[5r+k]` == `in<k>` for r=0..4, k=0..4.
  - `com` is high exactly 5 cycles after the `init` edge, for one cycle.
- Partial lanes: only lane 2 holds 3 words (10, 11, 12), `init` → `mem[2]`=10, `mem[7]`=11, `mem[12]`=12. All other entries remain 0.
- Offset and overflow: `base_address`=10, all lanes full of value 7 → `mem[10..24]`=7, `mem[0..9]` unchanged. Lanes each lose 5 entries (pops still occur for discarded writes).
- Concurrency: `wr_en`=5'b11111 and `init` during a RUN → the run is not restarted. FIFO counts are unchanged while full, since each lane pushes and pops in the same cycle.
- Reset during RUN: assert `rst` at E2 → `com` is never asserted, `mem` is all 0, state is IDLE.

Source files
------------

// File: rtl/fifo_mem_pkg.sv
// Shared constants and controller state encoding for the fifo_mem staging block.
package fifo_mem_pkg;
    localparam int DATA_W    = 32;
    localparam int N         = 5;
    localparam int MEM_WORDS = N * N;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/lane_fifo.sv
// Synchronous lane FIFO with fall-through head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module lane_fifo
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    import fifo_mem_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] store [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end
endmodule

// File: rtl/fifo_mem.sv
// Five lane FIFOs drained row by row into a 5x5 result memory on an init pulse;
// com pulses for one cycle once the fifth row has been written.
module fifo_mem
#(
    parameter int DATA_W = fifo_mem_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int N      = fifo_mem_pkg::N
)(
    input  logic              init,
    output logic              com,
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      wr_en,
    input  logic [7:0]        base_address,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4
);
    import fifo_mem_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);

    state_t            state;
    logic [2:0]        row;
    logic [7:0]        base_q;
    logic [7:0]        row_base;
    logic [DATA_W-1:0] mem       [MEM_WORDS];
    logic [DATA_W-1:0] lane_din  [N];
    logic [DATA_W-1:0] lane_dout [N];
    logic [7:0]        lane_addr [N];
    logic [N-1:0]      lane_full;
    logic [N-1:0]      lane_empty;
    logic [N-1:0]      lane_pop;

    assign lane_din[0] = in0;
    assign lane_din[1] = in1;
    assign lane_din[2] = in2;
    assign lane_din[3] = in3;
    assign lane_din[4] = in4;

    // Address arithmetic wraps at 8 bits; out-of-range results are dropped below.
    assign row_base = base_q + 8'(row) * 8'd5;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            lane_addr[k] = row_base + 8'(k);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lane_pop[k] = (state == S_RUN) && !lane_empty[k];

        lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (wr_en[k]),
            .pop   (lane_pop[k]),
            .din   (lane_din[k]),
            .dout  (lane_dout[k]),
            .full  (lane_full[k]),
            .empty (lane_empty[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            row    <= '0;
            base_q <= '0;
            com    <= 1'b0;
        end else begin
            com <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init) begin
                        state  <= S_RUN;
                        row    <= '0;
                        base_q <= base_address;
                    end
                end
                S_RUN: begin
                    row <= row + 3'd1;
                    if (row == 3'd4) begin
                        state <= S_IDLE;
                        com   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A popped word lands in memory on the same edge it leaves its FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (lane_pop[k] && (lane_addr[k] < 8'(MEM_WORDS)))
                    mem[lane_addr[k][AW-1:0]] <= lane_dout[k];
            end
        end
    end
endmodule

// File: tb/tb_fifo_mem.sv
// Randomised scoreboard bench for fifo_mem against a queue-based reference model.
module tb_fifo_mem;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int NL    = 5;
    localparam int MW    = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic          com;
    logic [NL-1:0] wr_en;
    logic [7:0]    base_address;
    logic [DW-1:0] in_v [NL];

    fifo_mem #(.DATA_W(DW), .DEPTH(DEPTH), .N(NL)) dut (
        .init         (init),
        .com          (com),
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .base_address (base_address),
        .in0          (in_v[0]),
        .in1          (in_v[1]),
        .in2          (in_v[2]),
        .in3          (in_v[3]),
        .in4          (in_v[4])
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int count_nonzero(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (dut.mem[i] !== '0) n++;
        return n;
    endfunction

    // Reference model: per-lane queues, a 25-word memory image and a run tracker.
    typedef struct packed {
        int              cyc;
        logic [MW*DW-1:0] img;
    } exp_t;

    logic [DW-1:0] mq [NL][$];
    logic [DW-1:0] m_mem [MW];
    bit            m_run;
    int            m_row;
    int            m_base;
    exp_t          exp_q [$];

    always @(posedge clk) begin
        bit            popped [NL];
        logic [DW-1:0] w;
        int            a;
        exp_t          e;
        if (rst) begin
            for (int k = 0; k < NL; k++) mq[k].delete();
            for (int i = 0; i < MW; i++) m_mem[i] = '0;
            m_run  = 1'b0;
            m_row  = 0;
            m_base = 0;
            exp_q.delete();
        end else begin
            for (int k = 0; k < NL; k++) popped[k] = 1'b0;
            if (m_run) begin
                for (int k = 0; k < NL; k++) begin
                    if (mq[k].size() > 0) begin
                        w = mq[k].pop_front();
                        popped[k] = 1'b1;
                        a = (m_base + 5 * m_row + k) % 256;
                        if (a < MW) m_mem[a] = w;
                    end
                end
                if (m_row == 4) begin
                    m_run = 1'b0;
                    e.cyc = cyc;
                    for (int i = 0; i < MW; i++) e.img[i*DW +: DW] = m_mem[i];
                    exp_q.push_back(e);
                end else begin
                    m_row++;
                end
            end else if (init) begin
                m_run  = 1'b1;
                m_row  = 0;
                m_base = int'(base_address);
            end
            for (int k = 0; k < NL; k++)
                if (wr_en[k] && (mq[k].size() < DEPTH || popped[k])) mq[k].push_back(in_v[k]);
        end
        cyc++;
    end

    // Monitor: tracks flags, state and memory every cycle; pops the scoreboard on com.
    always @(negedge clk) begin
        int            bad;
        logic [NL-1:0] m_empty;
        logic [NL-1:0] m_full;
        bit            want_com;
        exp_t          e;
        if (!rst) begin
            for (int k = 0; k < NL; k++) begin
                m_empty[k] = (mq[k].size() == 0);
                m_full[k]  = (mq[k].size() == DEPTH);
            end
            check("lane_empty", longint'(dut.lane_empty), longint'(m_empty));
            check("lane_full", longint'(dut.lane_full), longint'(m_full));
            check("state", longint'(dut.state), longint'(m_run));
            bad = -1;
            for (int i = 0; i < MW; i++)
                if (bad < 0 && dut.mem[i] !== m_mem[i]) bad = i;
            check("mem_track_first_bad_index", longint'(bad), -1);

            want_com = (exp_q.size() > 0) && (exp_q[0].cyc + 1 == cyc);
            check("com", longint'(com), longint'(want_com));
            if (exp_q.size() > 0 && cyc >= exp_q[0].cyc + 1) begin
                e = exp_q.pop_front();
                if (com === 1'b1 && want_com) begin
                    for (int i = 0; i < MW; i++)
                        check("com_mem_image", longint'(dut.mem[i]), longint'(e.img[i*DW +: DW]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        init = 1'b0;
        wr_en = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NL; k++) in_v[k] = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        init = 1'b0;
        wr_en = 5'b11111;
        base_address = 8'd0;
        rand_data();

        // Reset with pushes asserted: nothing may enter.
        tick(2);
        check("rst_com", longint'(com), 0);
        check("rst_state", longint'(dut.state), 0);
        check("rst_row", longint'(dut.row), 0);
        check("rst_base_q", longint'(dut.base_q), 0);
        check("rst_lane_empty", longint'(dut.lane_empty), 31);
        check("rst_mem_nonzero", longint'(count_nonzero(0, MW-1)), 0);

        // Fill with constant data; extra pushes are dropped.
        rst = 1'b0;
        tick(10);
        check("fill_full", longint'(dut.lane_full), 31);

        // Basic run at base 0.
        wr_en = '0;
        base_address = 8'd0;
        init = 1'b1;
        tick(1);
        init = 1'b0;
        tick(6);
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < NL; k++)
                check("basic_mem", longint'(dut.mem[5*r+k]), longint'(in_v[k]));

        // Partial lanes: only lane 2 holds 10, 11, 12.
        do_reset();
        check("partial_pre_mem_nonzero", longint'(count_nonzero(0, MW-1)), 0);
        wr_en = 5'b00100;
        for (int v = 10; v <= 12; v++) begin
            in_v[2] = DW'(v);
            tick(1);
        end
        wr_en = '0;
        init = 1'b1;
        tick(1);
        init = 1'b0;
        tick(6);
        check("partial_mem2", longint'(dut.mem[2]), 10);
        check("partial_mem7", longint'(dut.mem[7]), 11);
        check("partial_mem12", longint'(dut.mem[12]), 12);
        check("partial_others_nonzero",
              longint'(count_nonzero(0, MW-1)), 3);

        // Offset 10: rows 3 and 4 overflow, yet every lane still pops five words.
        do_reset();
        for (int k = 0; k < NL; k++) in_v[k] = 32'd7;
        wr_en = 5'b11111;
        tick(8);
        wr_en = '0;
        base_address = 8'd10;
        init = 1'b1;
        tick(1);
        init = 1'b0;
        tick(6);
        for (int i = 10; i < MW; i++) check("offset_mem_hi", longint'(dut.mem[i]), 7);
        check("offset_mem_lo_nonzero", longint'(count_nonzero(0, 9)), 0);
        check("offset_lane_empty", longint'(dut.lane_empty), 0);
        check("offset_lane_full", longint'(dut.lane_full), 0);

        // Concurrency: full lanes keep pushing while running; init mid-run ignored.
        do_reset();
        wr_en = 5'b11111;
        for (int c = 0; c < 8; c++) begin rand_data(); tick(1); end
        base_address = 8'd0;
        for (int c = 0; c < 9; c++) begin
            init = (c == 0 || c == 2 || c == 3);
            rand_data();
            tick(1);
            check("conc_full", longint'(dut.lane_full), 31);
        end
        init = 1'b0;
        wr_en = '0;

        // Back-to-back: init held high retriggers at E6.
        init = 1'b1;
        base_address = 8'd0;
        wr_en = 5'b11111;
        rand_data();
        tick(7);
        check("b2b_restart_state", longint'(dut.state), 1);
        init = 1'b0;
        wr_en = '0;
        tick(7);

        // Reset mid-run aborts without com and clears memory.
        wr_en = 5'b11111;
        tick(4);
        wr_en = '0;
        init = 1'b1;
        tick(1);
        init = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        check("abort_com", longint'(com), 0);
        check("abort_state", longint'(dut.state), 0);
        check("abort_mem_nonzero", longint'(count_nonzero(0, MW-1)), 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check("abort_no_com", longint'(com), 0);
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            wr_en = NL'($urandom);
            rand_data();
            init = ($urandom % 6 == 0);
            base_address = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % MW);
            rst = ($urandom % 150 == 0);
            tick(1);
        end
        rst = 1'b0;
        init = 1'b0;
        wr_en = '0;
        tick(8);
        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
